// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences a single-port RAM between a user port and the I/D-cache refill/writeback engines.
//   usr_*      single-word read/write port; usr_ack pulses with read data on usr_dout
//   ic_*       I-cache 8-word line refill; beats flagged by ic_rvalid, ic_ack with last beat
//   dc_*       D-cache 8-word refill (dc_we=0) or writeback (dc_we=1); widx selects dc_wdata
//   rdata/ridx shared refill beat data and word index
//   mem_*      RAM port; mem_dout arrives one cycle after a read enable
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_din,
    output logic [DATA_W-1:0] usr_dout,
    output logic              usr_ack,
    input  logic              ic_req,
    input  logic [ADDR_W-4:0] ic_line,
    output logic              ic_rvalid,
    output logic              ic_ack,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-4:0] dc_line,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_rvalid,
    output logic              dc_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        ridx,
    output logic [2:0]        widx,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, USER, USER_ACK, RD, RD_TAIL, WR} state_t;
    state_t state, state_n;
    logic [2:0] cnt, cnt_n, ridx_q;
    logic last_dc, last_dc_n, sel_dc, sel_dc_n, rvalid_q, grant_dc;
    logic [ADDR_W-4:0] line;
    // D-cache wins a tie unless it was the last cache served
    assign grant_dc = dc_req & (~ic_req | ~last_dc);
    assign line = sel_dc ? dc_line : ic_line;
    // read beats lag the address by one cycle to match RAM latency
    assign ic_rvalid = rvalid_q & ~sel_dc;
    assign dc_rvalid = rvalid_q & sel_dc;
    assign ridx = ridx_q;
    assign rdata = rvalid_q ? mem_dout : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_dc  <= 1'b0;
            sel_dc   <= 1'b0;
            rvalid_q <= 1'b0;
            ridx_q   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_dc  <= last_dc_n;
            sel_dc   <= sel_dc_n;
            rvalid_q <= state == RD;
            ridx_q   <= state == RD ? cnt : '0;
        end
    end
    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        last_dc_n = last_dc;
        sel_dc_n  = sel_dc;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        usr_ack   = 1'b0;
        usr_dout  = '0;
        ic_ack    = 1'b0;
        dc_ack    = 1'b0;
        widx      = '0;
        case (state)
            IDLE: begin
                if (usr_req) begin
                    state_n = USER;
                end else if (grant_dc) begin
                    state_n   = dc_we ? WR : RD;
                    sel_dc_n  = 1'b1;
                    last_dc_n = 1'b1;
                end else if (ic_req) begin
                    state_n   = RD;
                    sel_dc_n  = 1'b0;
                    last_dc_n = 1'b0;
                end
            end
            USER: begin
                mem_en   = 1'b1;
                mem_we   = usr_we;
                mem_addr = usr_addr;
                mem_din  = usr_din;
                state_n  = USER_ACK;
            end
            USER_ACK: begin
                usr_ack  = 1'b1;
                usr_dout = mem_dout;
                state_n  = IDLE;
            end
            RD: begin
                mem_en   = 1'b1;
                mem_addr = {line, cnt};
                cnt_n    = cnt + 3'd1;
                state_n  = cnt == 3'd7 ? RD_TAIL : RD;
            end
            RD_TAIL: begin
                ic_ack  = ~sel_dc;
                dc_ack  = sel_dc;
                state_n = IDLE;
            end
            WR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {dc_line, cnt};
                mem_din  = dc_wdata;
                widx     = cnt;
                dc_ack   = cnt == 3'd7;
                cnt_n    = cnt + 3'd1;
                state_n  = cnt == 3'd7 ? IDLE : WR;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural RAM.
module tb_mem_arbiter;
    logic clk, rst;
    logic usr_req, usr_we, usr_ack, ic_req, ic_rvalid, ic_ack;
    logic dc_req, dc_we, dc_rvalid, dc_ack, mem_en, mem_we;
    logic [12:0] usr_addr, mem_addr;
    logic [9:0] ic_line, dc_line;
    logic [31:0] usr_din, usr_dout, dc_wdata, rdata, mem_din, mem_dout;
    logic [2:0] ridx, widx;
    logic [31:0] ram [0:8191];
    logic ld_en;
    logic [12:0] ld_addr;
    logic [31:0] ld_data;
    logic [121:0] all_out;
    int checks = 0, errors = 0;
    int nacks, ic_beats, w[4], c[4];
    bit ridx_bad;
    logic [31:0] udout;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_din(usr_din),
        .usr_dout(usr_dout), .usr_ack(usr_ack),
        .ic_req(ic_req), .ic_line(ic_line), .ic_rvalid(ic_rvalid), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_we(dc_we), .dc_line(dc_line), .dc_wdata(dc_wdata),
        .dc_rvalid(dc_rvalid), .dc_ack(dc_ack),
        .rdata(rdata), .ridx(ridx), .widx(widx),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_din;
        if (mem_en && !mem_we) mem_dout <= ram[mem_addr];
    end

    assign dc_wdata = 32'd100 + {29'd0, widx};
    assign all_out = {usr_dout, usr_ack, ic_rvalid, ic_ack, dc_rvalid, dc_ack, rdata, ridx, widx,
                      mem_en, mem_we, mem_addr, mem_din};

    typedef struct {
        logic        req, we;
        logic [12:0] addr;
        logic [31:0] din;
        logic        en, mwe;
        logic [12:0] maddr;
        logic        ack;
        logic [31:0] dout;
        logic        chk_dout;
    } uvec_t;
    uvec_t tv[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        #1 check("reset_outputs", {6'd0, all_out}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs cycles from the current cycle 0 until n acks are seen; records who (1 usr, 2 ic, 3 dc) and when.
    task automatic run(input int n, input bit drop, input int raise_at, input int budget);
        bit su, si, sd;
        int cyc = 0;
        nacks = 0; ic_beats = 0; ridx_bad = 0; udout = '0;
        for (int i = 0; i < 4; i++) begin w[i] = 0; c[i] = 0; end
        while (nacks < n && cyc < budget) begin
            #1;
            su = usr_ack; si = ic_ack; sd = dc_ack;
            if (ic_rvalid) begin
                if (ridx != ic_beats[2:0]) ridx_bad = 1;
                ic_beats++;
            end
            if (su) udout = usr_dout;
            if (su && nacks < 4) begin w[nacks] = 1; c[nacks] = cyc; end
            if (su) nacks++;
            if (si && nacks < 4) begin w[nacks] = 2; c[nacks] = cyc; end
            if (si) nacks++;
            if (sd && nacks < 4) begin w[nacks] = 3; c[nacks] = cyc; end
            if (sd) nacks++;
            @(negedge clk);
            cyc++;
            if (drop && su) usr_req = 1'b0;
            if (drop && si) ic_req = 1'b0;
            if (drop && sd) dc_req = 1'b0;
            if (cyc == raise_at) begin
                usr_req = 1'b1; usr_we = 1'b0; usr_addr = 13'd5;
                dc_req = 1'b1; dc_we = 1'b0; dc_line = 10'd2;
            end
        end
        check("ack_count", nacks, n);
    endtask

    initial begin
        logic        exp_en, exp_v;
        logic [12:0] exp_addr;
        logic [2:0]  exp_ridx;
        tv[0] = '{1'b1, 1'b1, 13'd5, 32'd42, 1'b0, 1'b0, 13'd0, 1'b0, 32'd0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 13'd5, 32'd42, 1'b1, 1'b1, 13'd5, 1'b0, 32'd0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 13'd5, 32'd42, 1'b0, 1'b0, 13'd0, 1'b1, 32'd0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 13'd5, 32'd0,  1'b0, 1'b0, 13'd0, 1'b0, 32'd0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 13'd5, 32'd0,  1'b1, 1'b0, 13'd5, 1'b0, 32'd0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 13'd5, 32'd0,  1'b0, 1'b0, 13'd0, 1'b1, 32'd42, 1'b1};
        tv[6] = '{1'b0, 1'b0, 13'd0, 32'd0,  1'b0, 1'b0, 13'd0, 1'b0, 32'd0, 1'b0};
        tv[7] = '{1'b0, 1'b0, 13'd0, 32'd0,  1'b0, 1'b0, 13'd0, 1'b0, 32'd0, 1'b0};
        rst = 1'b1;
        usr_req = 0; usr_we = 0; usr_addr = '0; usr_din = '0;
        ic_req = 0; ic_line = '0; dc_req = 0; dc_we = 0; dc_line = '0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 13'd24 + 13'(i); ld_data = 32'(i + 1);
        end
        @(negedge clk);
        ld_en = 1'b0;
        #1 check("reset_outputs", {6'd0, all_out}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_release", {6'd0, all_out}, 128'd0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            usr_req = tv[i].req; usr_we = tv[i].we; usr_addr = tv[i].addr; usr_din = tv[i].din;
            #1;
            check($sformatf("usr_vec%0d", i), {mem_en, mem_we, mem_addr, usr_ack},
                  {tv[i].en, tv[i].mwe, tv[i].maddr, tv[i].ack});
            if (tv[i].chk_dout) check($sformatf("usr_dout%0d", i), usr_dout, tv[i].dout);
            @(negedge clk);
        end

        ic_req = 1'b1; ic_line = 10'd3;
        for (int k = 0; k <= 10; k++) begin
            #1;
            exp_en = k >= 1 && k <= 8;
            exp_addr = exp_en ? 13'(24 + k - 1) : 13'd0;
            exp_v = k >= 2 && k <= 9;
            exp_ridx = exp_v ? 3'(k - 2) : 3'd0;
            check($sformatf("refill_c%0d", k),
                  {mem_en, mem_we, mem_addr, ic_rvalid, ic_ack, dc_rvalid, dc_ack, ridx},
                  {exp_en, 1'b0, exp_addr, exp_v, k == 9, 1'b0, 1'b0, exp_ridx});
            if (exp_v) check($sformatf("refill_rdata%0d", k - 2), rdata, 32'(k - 1));
            @(negedge clk);
            if (k == 9) ic_req = 1'b0;
        end

        do_reset();
        dc_req = 1'b1; dc_we = 1'b0; dc_line = 10'd2; ic_req = 1'b1; ic_line = 10'd3;
        run(3, 1'b0, -1, 60);
        dc_req = 1'b0; ic_req = 1'b0;
        check("rr_order", {w[0], w[1], w[2]}, {32'd3, 32'd2, 32'd3});
        check("rr_cycles", {c[0], c[1], c[2]}, {32'd9, 32'd19, 32'd29});
        repeat (2) @(negedge clk);

        ic_req = 1'b1; ic_line = 10'd3;
        run(3, 1'b1, 4, 80);
        check("mid_order", {w[0], w[1], w[2]}, {32'd2, 32'd1, 32'd3});
        check("mid_cycles", {c[0], c[1], c[2]}, {32'd9, 32'd12, 32'd22});
        check("mid_ic_beats", ic_beats, 8);
        check("mid_ridx_seq", ridx_bad, 1'b0);
        check("mid_usr_dout", udout, 32'd42);
        repeat (2) @(negedge clk);

        dc_req = 1'b1; dc_we = 1'b1; dc_line = 10'd1;
        run(1, 1'b1, -1, 30);
        dc_we = 1'b0;
        check("wb_ack", {w[0], c[0]}, {32'd3, 32'd8});
        for (int i = 0; i < 8; i++) check($sformatf("wb_ram%0d", 8 + i), ram[8 + i], 32'(100 + i));
        repeat (2) @(negedge clk);

        ic_req = 1'b1; ic_line = 10'd3;
        repeat (4) @(negedge clk);
        #1 check("rst_mid_addr", {mem_en, mem_addr}, {1'b1, 13'd27});
        rst = 1'b1;
        #1 check("rst_mid_now", {6'd0, all_out}, 128'd0);
        @(negedge clk);
        ic_req = 1'b0;
        #1 check("rst_mid_held", {6'd0, all_out}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_release", {6'd0, all_out}, 128'd0);
        @(negedge clk);
        ic_req = 1'b1;
        run(1, 1'b1, -1, 30);
        check("rerequest_ack", {w[0], c[0]}, {32'd2, 32'd9});
        check("rerequest_beats", ic_beats, 8);
        check("rerequest_ridx", ridx_bad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single-port main memory between three requesters: the instruction-cache refill engine, the data-cache refill/writeback engine, and the user (bench/debug) port. It converts cache requests into 8-word line bursts and user requests into single-word accesses. It owns every memory control signal. It sits between the PipelineMIPS cache controllers and the main-memory RAM.

## Interface
- `DATA_W`, default 32: memory word width.
- `ADDR_W`, default 13: word-address width; line address is `ADDR_W-3`, 8 words per line.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `usr_req` in 1: user single-word request; held until `usr_ack`.
- `usr_we` in 1: 1 = write, 0 = read.
- `usr_addr` in ADDR_W: word address.
- `usr_din` in DATA_W: write data.
- `usr_dout` out DATA_W: read data, valid while `usr_ack`=1.
- `usr_ack` out 1: one-cycle completion pulse.
- `ic_req` in 1: I-cache line-refill request; held until `ic_ack`.
- `ic_line` in ADDR_W-3: line address.
- `ic_rvalid` out 1: read beat valid.
- `ic_ack` out 1: one-cycle pulse with the last beat.
- `dc_req` in 1: D-cache line request; held until `dc_ack`.
- `dc_we` in 1: 1 = writeback, 0 = refill.
- `dc_line` in ADDR_W-3: line address.
- `dc_wdata` in DATA_W: writeback word selected by `widx`.
- `dc_rvalid` out 1: read beat valid.
- `dc_ack` out 1: one-cycle completion pulse.
- `rdata` out DATA_W: shared read-beat data; equals `mem_dout`.
- `ridx` out 3: word index of the current read beat.
- `widx` out 3: word index being written; combinational.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_din` out DATA_W: RAM port. RAM read data appears on `mem_dout` one cycle after `mem_en` with `mem_we`=0.
- `mem_dout` in DATA_W: RAM read data.

## Operation
- FSM states: IDLE, USER, USER_ACK, RD, RD_TAIL, WR.
- IDLE arbitration, evaluated every IDLE cycle:
  - `usr_req` wins over both caches.
  - Otherwise `dc_req` vs `ic_req` is round-robin on 1-bit `last`: the requester not granted last time wins a tie.
  - A lone requester always wins.
  - `last` updates on grant.
- USER: drive `mem_en`=1, `mem_we`=`usr_we`, `mem_addr`=`usr_addr`, `mem_din`=`usr_din`. Next state USER_ACK.
- USER_ACK: `usr_ack`=1, `usr_dout`=`mem_dout`; for a write, `usr_dout` is don't-care. Next state IDLE.
- RD (cache refill):
  - 3-bit counter `cnt` runs 0..7; `mem_en`=1, `mem_we`=0, `mem_addr`={line,`cnt`}.
  - Registered `rvalid` and `ridx`=`cnt` lag the address by one cycle and are routed to the granted cache only.
  - After `cnt`=7 go to RD_TAIL: last beat plus the granted `*_ack`, then IDLE.
- WR (D-cache writeback only):
  - `mem_en`=`mem_we`=1, `mem_addr`={`dc_line`,`cnt`}, `mem_din`=`dc_wdata`, `widx`=`cnt`.
  - `dc_ack`=1 in the `cnt`=7 cycle, then IDLE.
- Line address is sampled from the requester's port each cycle; the requester holds it stable while `req` is high.
- A requester must drop `req` the cycle after its ack. Otherwise a new transaction starts.
- Outside active states, all `mem_*`, `*_rvalid`, `*_ack` are 0 and `widx`/`ridx` are 0.

## Timing
- Cycle 0 is the IDLE cycle in which the winning `req` is sampled high.
- User access: RAM access in cycle 1, `usr_ack` in cycle 2, IDLE in cycle 3. Back-to-back user ops complete every 3 cycles.
- Refill:
  - Addresses in cycles 1–8.
  - `*_rvalid` in cycles 2–9 with `ridx` 0..7 in order.
  - `*_ack` in cycle 9; IDLE in cycle 10.
- Writeback: writes in cycles 1–8, `dc_ack` in cycle 8, IDLE in cycle 9.
- The next grant is never earlier than the first IDLE cycle after a transaction. Grants never overlap, and a burst is never preempted.
- Requests arriving mid-transaction wait. Priority is re-evaluated at IDLE.
- Reset (asynchronous, any cycle, including mid-burst): state IDLE, `cnt`=0, `rvalid` pipeline cleared, `last`=I-cache (D-cache wins the first tie). All outputs are 0 while `rst`=1 and in the first cycle after release. An interrupted burst is not resumed; the requester must re-request.

## Test plan
- User write addr 5 data 42, then user read addr 5 -> `mem_we` pulse in cycle 1; read `usr_ack` in cycle 2 with `usr_dout`=42.
- RAM words 24..31 preloaded 1..8; `ic_req` line 3 -> `mem_addr` 24..31 in cycles 1–8; `ic_rvalid` cycles 2–9 with `rdata` 1..8 and `ridx` 0..7; `ic_ack` cycle 9; `dc_rvalid` stays 0.
- `dc_req`+`ic_req` together, held, after reset -> D-cache served first, then I-cache, then D-cache again (round-robin alternation).
- `usr_req`, `dc_req`, `ic_req` all raised during an I-cache burst -> the burst completes unbroken; user is granted at the next IDLE, then D-cache.
- D-cache writeback line 1 with `dc_wdata`=100+`widx` -> RAM words 8..15 hold 100..107; `dc_ack` in cycle 8.
- `rst` asserted in cycle 4 of a refill -> all outputs 0 immediately, no `ic_ack`; a re-request after release gives a full 8-beat burst.
